// File: rtl/sap_pkg.sv
// Shared opcode constants, T-state encodings and ring-counter helpers for the
// SAP-style controller sequencer.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T_STATE_W = 6;

    // Bits [5:0] are the visible one-hot T-state; bit 6 marks HALT.
    typedef enum logic [6:0] {
        ST_T1   = 7'b000_0001,
        ST_T2   = 7'b000_0010,
        ST_T3   = 7'b000_0100,
        ST_T4   = 7'b000_1000,
        ST_T5   = 7'b001_0000,
        ST_T6   = 7'b010_0000,
        ST_HALT = 7'b100_0000
    } state_e;

    localparam logic [T_STATE_W-1:0] T_STATE_RESET = 6'b00_0001;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic state_e ring_next(input state_e cur, input logic hlt_req);
        state_e nxt;
        case (cur)
            ST_T1:   nxt = ST_T2;
            ST_T2:   nxt = ST_T3;
            ST_T3:   nxt = ST_T4;
            ST_T4:   nxt = hlt_req ? ST_HALT : ST_T5;
            ST_T5:   nxt = ST_T6;
            ST_T6:   nxt = ST_T1;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_T1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-state ring with a sticky HALT state; only reset leaves HALT.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic   clk,
    input  logic   low_rst,
    input  logic   hlt_req,
    output state_e state
);

    // state   | meaning
    // ST_T1   | fetch: PC onto bus, load MAR
    // ST_T2   | increment PC
    // ST_T3   | ROM onto bus, load IR
    // ST_T4   | execute 1 (HLT request sampled here)
    // ST_T5   | execute 2
    // ST_T6   | execute 3
    // ST_HALT | stopped, all controls idle until reset

    state_e state_q;
    state_e state_d;

    always_comb begin
        state_d = ring_next(state_q, hlt_req);
    end

    always_ff @(posedge clk or negedge low_rst) begin
        if (!low_rst) begin
            state_q <= ST_T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// Controller/sequencer: T-state ring plus zero-latency control decode of the
// registered state and the instruction opcode nibble.
module controller_sequencer
    import sap_pkg::*;
(
    input  logic                 clk,
    input  logic                 low_rst,
    input  logic [3:0]           opcode,
    output logic                 pc_inc,
    output logic                 pc_o_en,
    output logic                 low_mar_ld,
    output logic                 low_mem_o_en,
    output logic                 low_ir_ld,
    output logic                 low_ir_o_en,
    output logic                 low_a_ld,
    output logic                 a_o_en,
    output logic                 low_b_ld,
    output logic                 alu_sub,
    output logic                 alu_o_en,
    output logic                 low_out_ld,
    output logic [T_STATE_W-1:0] t_state,
    output logic                 halt
);

    state_e     state;
    logic       hlt_req;
    logic [6:0] state_bits;

    assign hlt_req    = (state == ST_T4) && (opcode == OP_HLT);
    assign state_bits = state;

    sap_ring_counter u_ring (
        .clk     (clk),
        .low_rst (low_rst),
        .hlt_req (hlt_req),
        .state   (state)
    );

    always_comb begin
        pc_inc       = 1'b0;
        pc_o_en      = 1'b0;
        low_mar_ld   = 1'b1;
        low_mem_o_en = 1'b1;
        low_ir_ld    = 1'b1;
        low_ir_o_en  = 1'b1;
        low_a_ld     = 1'b1;
        a_o_en       = 1'b0;
        low_b_ld     = 1'b1;
        alu_sub      = 1'b0;
        alu_o_en     = 1'b0;
        low_out_ld   = 1'b1;
        t_state      = state_bits[T_STATE_W-1:0];
        halt         = state_bits[6];

        // Reset gates the decode directly so an aborted instruction never
        // leaves a load strobe active while the ring is being forced to T1.
        if (!low_rst) begin
            t_state = T_STATE_RESET;
            halt    = 1'b0;
        end else begin
            case (state)
                ST_T1: begin
                    pc_o_en    = 1'b1;
                    low_mar_ld = 1'b0;
                end
                ST_T2: begin
                    pc_inc = 1'b1;
                end
                ST_T3: begin
                    low_mem_o_en = 1'b0;
                    low_ir_ld    = 1'b0;
                end
                ST_T4: begin
                    if (is_mem_op(opcode)) begin
                        low_ir_o_en = 1'b0;
                        low_mar_ld  = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        a_o_en     = 1'b1;
                        low_out_ld = 1'b0;
                    end
                end
                ST_T5: begin
                    if (opcode == OP_LDA) begin
                        low_mem_o_en = 1'b0;
                        low_a_ld     = 1'b0;
                    end else if (is_alu_op(opcode)) begin
                        low_mem_o_en = 1'b0;
                        low_b_ld     = 1'b0;
                    end
                end
                ST_T6: begin
                    if (is_alu_op(opcode)) begin
                        alu_o_en = 1'b1;
                        low_a_ld = 1'b0;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench: directed scenarios plus randomized opcode/reset traffic
// compared against a step-counter reference model.
module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       low_rst;
    logic [3:0] opcode;
    logic       pc_inc, pc_o_en, low_mar_ld, low_mem_o_en, low_ir_ld, low_ir_o_en;
    logic       low_a_ld, a_o_en, low_b_ld, alu_sub, alu_o_en, low_out_ld;
    logic [5:0] t_state;
    logic       halt;

    controller_sequencer dut (
        .clk          (clk),
        .low_rst      (low_rst),
        .opcode       (opcode),
        .pc_inc       (pc_inc),
        .pc_o_en      (pc_o_en),
        .low_mar_ld   (low_mar_ld),
        .low_mem_o_en (low_mem_o_en),
        .low_ir_ld    (low_ir_ld),
        .low_ir_o_en  (low_ir_o_en),
        .low_a_ld     (low_a_ld),
        .a_o_en       (a_o_en),
        .low_b_ld     (low_b_ld),
        .alu_sub      (alu_sub),
        .alu_o_en     (alu_o_en),
        .low_out_ld   (low_out_ld),
        .t_state      (t_state),
        .halt         (halt)
    );

    always #5 clk = ~clk;

    // Controls as a vector of "asserted" flags, independent of pin polarity.
    localparam int C_PC_INC = 11, C_PC_OE = 10, C_MAR = 9, C_MEM = 8, C_IRLD = 7, C_IROE = 6;
    localparam int C_ALD = 5, C_AOE = 4, C_BLD = 3, C_SUB = 2, C_ALUOE = 1, C_OUT = 0;

    logic [11:0] ctrl_act;
    assign ctrl_act = {pc_inc, pc_o_en, ~low_mar_ld, ~low_mem_o_en, ~low_ir_ld, ~low_ir_o_en,
                       ~low_a_ld, a_o_en, ~low_b_ld, alu_sub, alu_o_en, ~low_out_ld};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: instruction step 0..5 (T1..T6) and a halted flag.
    int m_step;
    bit m_halt;

    function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op,
                                             input bit halted, input logic rst_n);
        logic [11:0] v;
        v = '0;
        if (!rst_n || halted) return v;
        case (step)
            0: begin v[C_PC_OE] = 1'b1; v[C_MAR] = 1'b1; end
            1: v[C_PC_INC] = 1'b1;
            2: begin v[C_MEM] = 1'b1; v[C_IRLD] = 1'b1; end
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    v[C_IROE] = 1'b1; v[C_MAR] = 1'b1;
                end else if (op == 4'hE) begin
                    v[C_AOE] = 1'b1; v[C_OUT] = 1'b1;
                end
            end
            4: begin
                if (op == 4'h0) begin
                    v[C_MEM] = 1'b1; v[C_ALD] = 1'b1;
                end else if (op == 4'h1 || op == 4'h2) begin
                    v[C_MEM] = 1'b1; v[C_BLD] = 1'b1;
                end
            end
            5: begin
                if (op == 4'h1 || op == 4'h2) begin
                    v[C_ALUOE] = 1'b1; v[C_ALD] = 1'b1;
                end
                if (op == 4'h2) v[C_SUB] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] exp_tstate(input int step, input bit halted, input logic rst_n);
        if (!rst_n) return 6'b000001;
        if (halted) return 6'b000000;
        return 6'(1 << step);
    endfunction

    task automatic model_check(input string tag);
        chk({tag, "_ctrl"}, 32'(ctrl_act), 32'(exp_ctrl(m_step, opcode, m_halt, low_rst)));
        chk({tag, "_tstate"}, 32'(t_state), 32'(exp_tstate(m_step, m_halt, low_rst)));
        chk({tag, "_halt"}, 32'(halt), 32'(low_rst && m_halt));
    endtask

    // Advance one clock; the model consumes the opcode seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (low_rst && !m_halt) begin
            if (m_step == 3 && opcode == 4'hF) m_halt = 1'b1;
            else m_step = (m_step + 1) % 6;
        end
        #1;
    endtask

    task automatic apply_reset(input string tag);
        low_rst = 1'b0;
        m_step  = 0;
        m_halt  = 1'b0;
        #1;
        model_check({tag, "_during"});
        low_rst = 1'b1;
        #1;
    endtask

    task automatic run_to_t1();
        if (m_halt) apply_reset("to_t1");
        for (int k = 0; k < 6 && m_step != 0; k++) tick();
        chk("run_to_t1_step", 32'(m_step), 32'd0);
    endtask

    always @(negedge clk) begin
        int n;
        n = int'(pc_o_en) + int'(a_o_en) + int'(alu_o_en) + int'(!low_mem_o_en) + int'(!low_ir_o_en);
        chk("bus_one_driver", 32'(n <= 1), 32'd1);
    end

    logic [5:0] exp_ts [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};

    initial begin
        low_rst = 1'b0;
        opcode  = 4'h0;
        m_step  = 0;
        m_halt  = 1'b0;
        #2;
        model_check("por");
        chk("por_tstate", 32'(t_state), 32'h01);
        tick();
        tick();
        model_check("rst_held");
        low_rst = 1'b1;
        #1;
        model_check("rst_release");

        // LDA ring walk
        opcode = 4'h0;
        for (int i = 0; i < 7; i++) begin
            chk("lda_tstate", 32'(t_state), 32'(exp_ts[i]));
            chk("lda_mar", 32'(low_mar_ld), (i == 0 || i == 3 || i == 6) ? 32'd0 : 32'd1);
            chk("lda_ald", 32'(low_a_ld), (i == 4) ? 32'd0 : 32'd1);
            model_check("lda");
            tick();
        end
        run_to_t1();

        // SUB
        opcode = 4'h2;
        for (int i = 0; i < 6; i++) begin
            model_check("sub");
            if (i == 4) begin
                chk("sub_t5_bld", 32'(low_b_ld), 32'd0);
                chk("sub_t5_mem", 32'(low_mem_o_en), 32'd0);
            end
            if (i == 5) begin
                chk("sub_t6_alusub", 32'(alu_sub), 32'd1);
                chk("sub_t6_aluoe", 32'(alu_o_en), 32'd1);
                chk("sub_t6_ald", 32'(low_a_ld), 32'd0);
            end
            tick();
        end

        // OUT
        opcode = 4'hE;
        for (int i = 0; i < 6; i++) begin
            model_check("out");
            if (i == 3) begin
                chk("out_t4_aoe", 32'(a_o_en), 32'd1);
                chk("out_t4_outld", 32'(low_out_ld), 32'd0);
            end
            if (i == 4 || i == 5) chk("out_t56_idle", 32'(ctrl_act), 32'd0);
            tick();
        end

        // HLT
        opcode = 4'hF;
        for (int i = 0; i < 4; i++) begin
            model_check("hlt");
            tick();
        end
        chk("hlt_halt", 32'(halt), 32'd1);
        chk("hlt_tstate", 32'(t_state), 32'd0);
        chk("hlt_ctrl", 32'(ctrl_act), 32'd0);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom_range(0, 15));
            #1;
            chk("hlt_hold_halt", 32'(halt), 32'd1);
            chk("hlt_hold_tstate", 32'(t_state), 32'd0);
            model_check("hlt_hold");
            tick();
        end
        apply_reset("hlt_exit");
        chk("hlt_exit_tstate", 32'(t_state), 32'h01);
        chk("hlt_exit_pcoe", 32'(pc_o_en), 32'd1);
        chk("hlt_exit_halt", 32'(halt), 32'd0);

        // Asynchronous reset in the middle of ADD T5
        opcode = 4'h1;
        for (int i = 0; i < 4; i++) tick();
        chk("add_t5_bld", 32'(low_b_ld), 32'd0);
        chk("add_t5_tstate", 32'(t_state), 32'h10);
        low_rst = 1'b0;
        m_step  = 0;
        m_halt  = 1'b0;
        #1;
        chk("arst_ctrl", 32'(ctrl_act), 32'd0);
        chk("arst_tstate", 32'(t_state), 32'h01);
        chk("arst_halt", 32'(halt), 32'd0);
        low_rst = 1'b1;
        #1;
        chk("arst_rel_tstate", 32'(t_state), 32'h01);
        chk("arst_rel_pcoe", 32'(pc_o_en), 32'd1);
        chk("arst_rel_mar", 32'(low_mar_ld), 32'd0);
        chk("arst_rel_bld", 32'(low_b_ld), 32'd1);
        model_check("arst_rel");
        tick();
        chk("arst_next_tstate", 32'(t_state), 32'h02);
        run_to_t1();

        // Every opcode through a full instruction
        for (int op = 0; op < 16; op++) begin
            run_to_t1();
            opcode = 4'(op);
            for (int i = 0; i < 6; i++) begin
                #1;
                model_check("sweep");
                tick();
            end
        end

        // Random opcodes with occasional mid-cycle resets
        for (int n = 0; n < 2000; n++) begin
            opcode = 4'($urandom_range(0, 15));
            if (m_halt && $urandom_range(0, 7) == 0) apply_reset("rand_halt_rst");
            else if ($urandom_range(0, 99) == 0) apply_reset("rand_rst");
            #1;
            model_check("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
